// File: rtl/datapath_pkg.sv
// Shared datapath types and widths for the operand-fetch stage and the shifter.
package datapath_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ_A  = 2'd1,
    READ_B  = 2'd2,
    PRESENT = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_t;

  // Captured fetch request: both source addresses plus the shift code.
  typedef struct packed {
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    shift_op_t         shift;
  } fetch_req_t;

endpackage

// File: rtl/regfile.sv
// NREGS x DATA_W register file: one synchronous write port, one combinational
// read port that forwards same-cycle write data on an address match.
module regfile
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] mem [NREGS];

  // Storage: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read with write-through so a same-cycle write is seen by the reader.
  always_comb begin
    rd_data_c = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_c = wr_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: accepts a request, reads A then B from the register
// file, and holds A/B/shift for the downstream shifter until accepted.
module operand_fetch
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [1:0]        req_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [1:0]        out_shift,
  output logic              busy
);

  fetch_state_t      state_q, state_d;
  fetch_req_t        req_q, req_d;
  logic [DATA_W-1:0] out_a_d, out_b_d;
  logic              out_valid_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data_c;

  regfile u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data_c (rd_data_c)
  );

  // Single read port is shared: A address in READ_A, B address otherwise.
  assign rd_addr   = (state_q == READ_A) ? req_q.a_addr : req_q.b_addr;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_shift = 2'(req_q.shift);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    out_a_d     = out_a;
    out_b_d     = out_b;
    out_valid_d = out_valid;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.a_addr = req_a_addr;
          req_d.b_addr = req_b_addr;
          req_d.shift  = shift_op_t'(req_shift);
          state_d      = READ_A;
        end
      end
      READ_A: begin
        out_a_d = rd_data_c;
        state_d = READ_B;
      end
      READ_B: begin
        out_b_d     = rd_data_c;
        out_valid_d = 1'b1;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, captured request and operand registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      out_a     <= out_a_d;
      out_b     <= out_b_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, fetch, backpressure, bypass,
// same-address reads and reset in the middle of a fetch.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_a_addr;
  logic [2:0]  req_b_addr;
  logic [1:0]  req_shift;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [1:0]  out_shift;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  operand_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a_addr (req_a_addr),
    .req_b_addr (req_b_addr),
    .req_shift  (req_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_shift  (out_shift),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Drive a request for one cycle; returns one ns after the accepting edge.
  task automatic req(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh);
    req_valid = 1'b1; req_a_addr = a; req_b_addr = b; req_shift = sh;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_a_addr = '0; req_b_addr = '0; req_shift = '0;
    out_ready = 1'b1;

    // 1. asynchronous reset mid-cycle
    #13 reset_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_a", 32'(out_a), 32'h0);
    chk("rst_out_b", 32'(out_b), 32'h0);
    chk("rst_out_shift", 32'(out_shift), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    req(3'd0, 3'd0, 2'b00);
    tick(); tick();
    chk("r0_valid", 32'(out_valid), 32'h1);
    chk("r0_a", 32'(out_a), 32'h0);
    chk("r0_b", 32'(out_b), 32'h0);
    tick();
    chk("r0_done", 32'(out_valid), 32'h0);

    // 2. basic fetch and latency
    wr(3'd2, 16'h0381);
    wr(3'd5, 16'hF800);
    req(3'd2, 3'd5, 2'b10);
    chk("bf_busy", 32'(busy), 32'h1);
    chk("bf_ready_lo", 32'(req_ready), 32'h0);
    chk("bf_valid_c1", 32'(out_valid), 32'h0);
    tick();
    chk("bf_valid_c2", 32'(out_valid), 32'h0);
    tick();
    chk("bf_valid_c3", 32'(out_valid), 32'h1);
    chk("bf_a", 32'(out_a), 32'h0381);
    chk("bf_b", 32'(out_b), 32'hF800);
    chk("bf_shift", 32'(out_shift), 32'h2);
    tick();
    chk("bf_idle_valid", 32'(out_valid), 32'h0);
    chk("bf_idle_ready", 32'(req_ready), 32'h1);

    // 3. backpressure, with a second request held during PRESENT
    out_ready = 1'b0;
    req(3'd2, 3'd5, 2'b10);
    tick(); tick();
    req_valid = 1'b1; req_a_addr = 3'd0; req_b_addr = 3'd0; req_shift = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_a", 32'(out_a), 32'h0381);
      chk("bp_b", 32'(out_b), 32'hF800);
      chk("bp_shift", 32'(out_shift), 32'h2);
      chk("bp_ready_lo", 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(out_valid), 32'h0);
    chk("bp_rel_busy", 32'(busy), 32'h0);
    chk("bp_rel_ready", 32'(req_ready), 32'h1);
    chk("bp_rel_shift", 32'(out_shift), 32'h2);
    req_valid = 1'b0;
    tick();
    chk("bp_no_accept", 32'(busy), 32'h0);

    // 4. write-through during READ_B, then a write in PRESENT
    wr(3'd3, 16'h1111);
    out_ready = 1'b0;
    req(3'd2, 3'd3, 2'b01);
    tick();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hE381;
    tick();
    chk("wt_valid", 32'(out_valid), 32'h1);
    chk("wt_a", 32'(out_a), 32'h0381);
    chk("wt_b", 32'(out_b), 32'hE381);
    wr_data = 16'h0BAD;
    tick();
    wr_en = 1'b0;
    chk("wt_hold_b", 32'(out_b), 32'hE381);
    out_ready = 1'b1;
    tick();
    req(3'd3, 3'd2, 2'b00);
    tick(); tick();
    chk("wt_r3_new", 32'(out_a), 32'h0BAD);
    tick();

    // 5. same address for A and B
    wr(3'd7, 16'h03FF);
    req(3'd7, 3'd7, 2'b11);
    tick(); tick();
    chk("sa_a", 32'(out_a), 32'h03FF);
    chk("sa_b", 32'(out_b), 32'h03FF);
    chk("sa_shift", 32'(out_shift), 32'h3);
    tick();

    // 6. reset during READ_A
    req(3'd2, 3'd5, 2'b10);
    chk("mr_busy_pre", 32'(busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_ready", 32'(req_ready), 32'h1);
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_shift", 32'(out_shift), 32'h0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_valid", 32'(out_valid), 32'h0);
    end
    req(3'd2, 3'd5, 2'b00);
    tick(); tick();
    chk("mr_r2", 32'(out_a), 32'h0);
    chk("mr_r5", 32'(out_b), 32'h0);
    tick();
    req(3'd7, 3'd3, 2'b00);
    tick(); tick();
    chk("mr_r7", 32'(out_a), 32'h0);
    chk("mr_r3", 32'(out_b), 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
